floo_wormhole_arbiter: RTL and testbench
========================================

FLOO_WORMHOLE_ARBITER -- requirements
Module: floo_wormhole_arbiter

Interface
REQ-001 SHALL have parameter NumInp, default 5 (NumDirections), number of requesting input ports, legal range >= 2.
REQ-002 SHALL have parameter FlitWidth, default 64, flit payload width in bits.
REQ-003 SHALL have parameter OutDir, default Eject (route_direction_e), direction of the output port this arbiter serves.
REQ-004 SHALL have parameter AllowUTurn, default 0; when 0, input index equal to OutDir is masked, unless OutDir == Eject.
REQ-005 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have port valid_i, input, NumInp, per-input flit valid.
REQ-008 SHALL have port ready_o, output, NumInp, per-input flit accepted.
REQ-009 SHALL have port data_i, input, NumInp x FlitWidth, per-input flit payload.
REQ-010 SHALL have port last_i, input, NumInp, per-input last flit of packet.
REQ-011 SHALL have port valid_o, output, 1, output flit valid.
REQ-012 SHALL have port ready_i, input, 1, downstream ready.
REQ-013 SHALL have port data_o, output, FlitWidth, selected payload.
REQ-014 SHALL have port last_o, output, 1, selected last flag.
REQ-015 SHALL have port sel_o, output, clog2(NumInp), currently selected input index, for debug and performance counters.

Function
REQ-016 SHALL hold state: fsm in {Idle, Locked}; lock_idx; rr_ptr (both clog2(NumInp) bits).
REQ-017 SHALL, in Idle, set sel to the first unmasked input with valid_i high, searching from rr_ptr upward and wrapping NumInp-1 -> 0.
REQ-018 SHALL, in Locked, set sel = lock_idx regardless of other valid_i.
REQ-019 SHALL drive valid_o = valid_i[sel], data_o = data_i[sel] and last_o = last_i[sel], combinationally with zero cycle latency.
REQ-020 SHALL force valid_o, data_o and last_o to 0 when no input is eligible.
REQ-021 SHALL drive ready_o[i] = ready_i AND valid_o AND (i == sel); all other ready_o bits SHALL be 0.
REQ-022 SHALL never assert ready_o for a masked input, even if its valid_i is high.
REQ-023 SHALL transition Idle -> Locked, with lock_idx <= sel, when valid_o=1 and NOT (ready_i=1 AND last_o=1); this covers stalled single flits and multi-flit heads.
REQ-024 SHALL remain Idle on a handshake with last_o=1, and set rr_ptr <= sel+1 (wrapping to 0 after NumInp-1).
REQ-025 SHALL transition Locked -> Idle on a handshake with last_o=1, and set rr_ptr <= lock_idx+1 (wrapping).
REQ-026 SHALL keep lock_idx unchanged while Locked and valid_i[lock_idx]=0 (a packet bubble), with valid_o=0 and no other input granted.
REQ-027 SHALL leave rr_ptr unchanged in all cases other than those in REQ-024 and REQ-025.
REQ-028 SHALL keep data_o and last_o stable across cycles while valid_o=1 and ready_i=0, provided the inputs are stable.
REQ-029 SHALL reach sel_o = 0 on reset; otherwise sel_o = sel.

Reset
REQ-030 SHALL, on rst_i high, immediately (asynchronously) set fsm=Idle, lock_idx=0, rr_ptr=0.
REQ-031 SHALL, on reset asserted mid-packet, drop the lock; after release, arbitration restarts from input 0 with no residual grant.
REQ-032 SHALL, with valid_i all zero after reset, drive valid_o=0, ready_o=0, data_o=0, last_o=0 and sel_o=0.

Verification
REQ-033 Scenario 1: NumInp=5, inputs 1 and 3 each send single-flit packets continuously, ready_i=1 -> grants alternate 1,3,1,3 at one flit per cycle.
REQ-034 Scenario 2: input 2 sends a 4-flit packet, input 0 valid throughout -> output carries 2,2,2,2 then 0; ready_o[0]=0 during the packet.
REQ-035 Scenario 3: input 4 head flit with ready_i=0 for 3 cycles, input 1 raises valid in cycle 2 -> valid_o held, data_o unchanged, sel_o=4 until accepted.
REQ-036 Scenario 4: OutDir=East, AllowUTurn=0, only input 2 valid -> valid_o=0 and ready_o=0 indefinitely.
REQ-037 Scenario 5: rst_i pulsed after flit 2 of a 4-flit packet from input 3, input 1 also valid -> after release, input 1 is granted first.
REQ-038 Scenario 6: bubble in input 3's packet (valid_i[3]=0 for 2 cycles), input 0 valid -> valid_o=0 for 2 cycles, packet then resumes on input 3.

Source files
------------

// File: rtl/floo_wormhole_arbiter.sv
// Wormhole output arbiter: round-robin choice among eligible inputs, then the
// winner holds the output until its last flit handshakes.
module floo_wormhole_arbiter #(
    parameter int unsigned NumInp     = 5,
    parameter int unsigned FlitWidth  = 64,
    // Direction encoding: Eject=0, North=1, East=2, South=3, West=4
    parameter int unsigned OutDir     = 0,
    parameter bit          AllowUTurn = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumInp-1:0]              valid_i,
    output logic [NumInp-1:0]              ready_o,
    input  logic [NumInp*FlitWidth-1:0]    data_i,
    input  logic [NumInp-1:0]              last_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [FlitWidth-1:0]           data_o,
    output logic                           last_o,
    output logic [$clog2(NumInp)-1:0]      sel_o
);

    localparam int unsigned SelW  = $clog2(NumInp);
    localparam int unsigned Eject = 0;

    typedef enum logic {
        Idle,
        Locked
    } state_e;

    state_e            state_q;
    logic [SelW-1:0]   lock_idx_q;
    logic [SelW-1:0]   rr_ptr_q;

    logic [NumInp-1:0] mask;
    logic [NumInp-1:0] elig;
    logic [SelW-1:0]   rr_sel;
    logic              rr_found;
    logic [SelW-1:0]   sel;
    logic              grant_vld;

    function automatic logic [SelW-1:0] wrap_inc(input logic [SelW-1:0] v);
        if (32'(v) == NumInp - 1) return '0;
        return v + 1'b1;
    endfunction

    // A U-turn back onto the port we serve is blocked, except on the local eject port
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NumInp; i++) begin
            mask[i] = !AllowUTurn && (OutDir != Eject) && (i == OutDir);
        end
    end

    assign elig = valid_i & ~mask;

    always_comb begin
        int unsigned idx;
        idx      = 0;
        rr_sel   = '0;
        rr_found = 1'b0;
        for (int unsigned k = 0; k < NumInp; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NumInp) idx = idx - NumInp;
            if (!rr_found && elig[idx]) begin
                rr_found = 1'b1;
                rr_sel   = SelW'(idx);
            end
        end
    end

    // While locked, a bubble on the owner simply idles the output
    always_comb begin
        if (state_q == Locked) begin
            sel       = lock_idx_q;
            grant_vld = valid_i[lock_idx_q];
        end else begin
            sel       = rr_found ? rr_sel : '0;
            grant_vld = rr_found;
        end
    end

    always_comb begin
        ready_o = '0;
        if (grant_vld && ready_i) ready_o[sel] = 1'b1;
    end

    assign valid_o = grant_vld;
    assign data_o  = grant_vld ? data_i[sel*FlitWidth +: FlitWidth] : '0;
    assign last_o  = grant_vld & last_i[sel];
    assign sel_o   = sel;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= Idle;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            case (state_q)
                Idle: begin
                    if (grant_vld) begin
                        if (ready_i && last_o) begin
                            rr_ptr_q <= wrap_inc(sel);
                        end else begin
                            // Stalled single flit or multi-flit head: hold the grant
                            state_q    <= Locked;
                            lock_idx_q <= sel;
                        end
                    end
                end
                Locked: begin
                    if (grant_vld && ready_i && last_o) begin
                        state_q  <= Idle;
                        rr_ptr_q <= wrap_inc(lock_idx_q);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floo_wormhole_arbiter.sv
// Bench for floo_wormhole_arbiter: directed scenarios with literal expectations
// plus randomized traffic against a packet-level ownership model.
module tb_floo_wormhole_arbiter;

    localparam int N  = 5;
    localparam int FW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    valid = '0;
    logic [N-1:0]    last  = '0;
    logic [N*FW-1:0] data  = '0;
    logic            rdy   = 1'b0;

    logic [N-1:0]    ro_a, ro_b;
    logic            vo_a, vo_b, lo_a, lo_b;
    logic [FW-1:0]   do_a, do_b;
    logic [2:0]      so_a, so_b;

    int vectors     = 0;
    int miscompares = 0;

    // Model state per instance: packet owner (-1 = none) and next priority input
    int owner[2] = '{-1, -1};
    int prio[2]  = '{0, 0};

    always #5 clk = ~clk;

    floo_wormhole_arbiter #(.NumInp(N), .FlitWidth(FW)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ro_a), .data_i(data),
        .last_i(last), .valid_o(vo_a), .ready_i(rdy), .data_o(do_a), .last_o(lo_a),
        .sel_o(so_a)
    );

    floo_wormhole_arbiter #(.NumInp(N), .FlitWidth(FW), .OutDir(2), .AllowUTurn(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ro_b), .data_i(data),
        .last_i(last), .valid_o(vo_b), .ready_i(rdy), .data_o(do_b), .last_o(lo_b),
        .sel_o(so_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp(input int m, input string pfx, input logic [N-1:0] msk,
                             input logic vo, input logic [FW-1:0] dout, input logic lo,
                             input logic [N-1:0] ro, input logic [2:0] so);
        int            g;
        logic          ev;
        logic          el;
        logic [FW-1:0] ed;
        logic [N-1:0]  er;
        g = -1;
        if (owner[m] >= 0) begin
            g = owner[m];
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (prio[m] + k) % N;
                if (g < 0 && valid[idx] && !msk[idx]) g = idx;
            end
        end
        ev = 1'b0;
        if (g >= 0) ev = valid[g];
        ed = '0;
        el = 1'b0;
        er = '0;
        if (ev) begin
            ed = data[g*FW +: FW];
            el = last[g];
            if (rdy) er[g] = 1'b1;
        end
        chk({pfx, "_valid_o"}, 64'(vo), 64'(ev));
        chk({pfx, "_data_o"}, 64'(dout), 64'(ed));
        chk({pfx, "_last_o"}, 64'(lo), 64'(el));
        chk({pfx, "_ready_o"}, 64'(ro), 64'(er));
        if (g >= 0) chk({pfx, "_sel_o"}, 64'(so), 64'(g));
        if (ev && rdy && el) begin
            owner[m] = -1;
            prio[m]  = (g + 1) % N;
        end else if (ev) begin
            owner[m] = g;
        end
    endtask

    // Inputs change just after the rising edge, so the falling edge sees a settled cycle
    always @(negedge clk) begin
        if (rst) begin
            owner[0] = -1; owner[1] = -1;
            prio[0]  = 0;  prio[1]  = 0;
        end else begin
            model_cmp(0, "A", 5'b00000, vo_a, do_a, lo_a, ro_a, so_a);
            model_cmp(1, "B", 5'b00100, vo_b, do_b, lo_b, ro_b, so_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        tick();
        rst   = 1'b1;
        valid = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) data[i*FW +: FW] = FW'(16'h1000 + i);
        repeat (3) tick();
        rst = 1'b0;

        // Idle outputs after reset with nothing valid
        @(negedge clk);
        chk("rst_valid_o", 64'(vo_a), 64'(0));
        chk("rst_ready_o", 64'(ro_a), 64'(0));
        chk("rst_data_o", 64'(do_a), 64'(0));
        chk("rst_last_o", 64'(lo_a), 64'(0));
        chk("rst_sel_o", 64'(so_a), 64'(0));

        // Two single-flit streams alternate
        tick(); valid = 5'b01010; last = 5'b11111; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            chk("s1_sel", 64'(so_a), (i % 2 == 0) ? 64'(1) : 64'(3));
            chk("s1_valid", 64'(vo_a), 64'(1));
        end

        // Four-flit packet from input 2 locks out input 0
        pulse_reset(); valid = 5'b00010; last = 5'b11111; rdy = 1'b1;
        @(negedge clk);
        chk("s2_pre_sel", 64'(so_a), 64'(1));
        tick(); valid = 5'b00101; last = 5'b11011;
        for (int f = 0; f < 4; f++) begin
            if (f > 0) tick();
            if (f == 3) last[2] = 1'b1;
            @(negedge clk);
            chk("s2_sel", 64'(so_a), 64'(2));
            chk("s2_ready", 64'(ro_a), 64'(5'b00100));
        end
        tick();
        @(negedge clk);
        chk("s2_after_sel", 64'(so_a), 64'(0));
        chk("s2_after_ready", 64'(ro_a), 64'(5'b00001));

        // Stalled head on input 4 holds the output while input 1 arrives
        pulse_reset(); valid = 5'b10000; last = 5'b11111; rdy = 1'b0;
        data[4*FW +: FW] = 16'hBEEF;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            if (c == 1) valid = 5'b10010;
            @(negedge clk);
            chk("s3_sel", 64'(so_a), 64'(4));
            chk("s3_data", 64'(do_a), 64'(16'hBEEF));
            chk("s3_valid", 64'(vo_a), 64'(1));
        end
        tick(); rdy = 1'b1;
        @(negedge clk);
        chk("s3_accept_ready", 64'(ro_a), 64'(5'b10000));
        tick();
        @(negedge clk);
        chk("s3_next_sel", 64'(so_a), 64'(1));

        // Masked U-turn input never reaches the East output
        pulse_reset(); valid = 5'b00100; last = 5'b11111; rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            chk("s4_valid", 64'(vo_b), 64'(0));
            chk("s4_ready", 64'(ro_b), 64'(0));
        end

        // Reset mid-packet drops the lock on input 3
        pulse_reset(); valid = 5'b01000; last = 5'b00010; rdy = 1'b1;
        @(negedge clk);
        chk("s5_head_sel", 64'(so_a), 64'(3));
        tick(); valid = 5'b01010;
        @(negedge clk);
        chk("s5_flit2_sel", 64'(so_a), 64'(3));
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("s5_restart_sel", 64'(so_a), 64'(1));
        chk("s5_restart_ready", 64'(ro_a), 64'(5'b00010));

        // Bubble inside input 3's packet
        pulse_reset(); valid = 5'b01000; last = 5'b00001; rdy = 1'b1;
        @(negedge clk);
        chk("s6_head_sel", 64'(so_a), 64'(3));
        tick(); valid = 5'b01001;
        @(negedge clk);
        chk("s6_body_sel", 64'(so_a), 64'(3));
        tick(); valid = 5'b00001;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            chk("s6_bubble_valid", 64'(vo_a), 64'(0));
            chk("s6_bubble_ready", 64'(ro_a), 64'(0));
        end
        tick(); valid = 5'b01001; last = 5'b01001;
        @(negedge clk);
        chk("s6_resume_sel", 64'(so_a), 64'(3));
        chk("s6_resume_valid", 64'(vo_a), 64'(1));
        tick();
        @(negedge clk);
        chk("s6_next_sel", 64'(so_a), 64'(0));

        // Random traffic with occasional resets, checked by the model
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                valid[i]         = ($urandom_range(0, 9) < 6);
                last[i]          = ($urandom_range(0, 9) < 3);
                data[i*FW +: FW] = FW'($urandom);
            end
        end
        tick(); rst = 1'b0; valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
